// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch buffer: keeps up to MAX_OUT fetches in flight and queues
// in-order responses in a DEPTH-entry FIFO for decode. Redirects flush the FIFO and drop stale responses.
module fetch_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(MAX_OUT + 1);
    localparam logic [IW-1:0] MAX_OUT_C = IW'(MAX_OUT);
    localparam logic [31:0]   NOP       = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t [DEPTH-1:0] fifo_q;
    logic [31:0]        fetch_pc_q, resp_pc_q;
    logic [IW-1:0]      inflight_q, drop_q, inflight_d;
    logic [CW-1:0]      count_q;
    logic [PW-1:0]      head_q, tail_q;
    logic [31:0]        pending;
    logic               accept, resp, drop_rsp, push, pop;
    logic               unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // Slots already promised to outstanding non-dropped fetches count against the FIFO.
    always_comb begin
        pending    = 32'(count_q) + 32'(inflight_q) - 32'(drop_q);
        imem_req   = rst && !redirect && (inflight_q < MAX_OUT_C) && (pending < DEPTH);
        accept     = imem_req && imem_gnt;
        resp       = imem_rvalid && (inflight_q != '0);
        drop_rsp   = resp && (drop_q != '0);
        push       = resp && !redirect && (drop_q == '0);
        inflight_d = inflight_q + IW'(accept) - IW'(resp);
    end

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = !redirect && (count_q != '0);
    assign inst       = (count_q != '0) ? fifo_q[head_q].inst : NOP;
    assign inst_pc    = (count_q != '0) ? fifo_q[head_q].pc : '0;
    assign pop        = inst_valid && inst_ready;

    always_ff @(posedge clk) begin
        if (push) fifo_q[tail_q] <= '{pc: resp_pc_q, inst: imem_rdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else if (redirect) begin
            // Everything still outstanding after this cycle's response is stale.
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            resp_pc_q  <= {redirect_pc[31:2], 2'b00};
            inflight_q <= inflight_d;
            drop_q     <= inflight_d;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (accept)   fetch_pc_q <= fetch_pc_q + 32'd4;
            if (drop_rsp) drop_q     <= drop_q - IW'(1);
            if (push) begin
                tail_q    <= tail_q + PW'(1);
                resp_pc_q <= resp_pc_q + 32'd4;
            end
            if (pop) head_q <= head_q + PW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer: streaming/stall table plus redirect,
// alignment, address-wrap and mid-stream reset sequences against a 1-cycle memory model.
module tb_fetch_prefetch_buffer;

    logic        clk = 1'b0;
    logic        rst, redirect, imem_gnt, imem_rvalid, inst_ready;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, inst, inst_pc;

    fetch_prefetch_buffer dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        bit          gnt;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl[21];
    logic [31:0] pend_q[$];
    bit          mem_en, force_rv;
    logic [31:0] force_data;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    function automatic logic [31:0] img(input logic [31:0] a);
        return ~a;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Present this cycle's memory response, then let combinational outputs settle.
    task automatic drive();
        if (force_rv) begin
            imem_rvalid = 1'b1;
            imem_rdata  = force_data;
        end else if (mem_en && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = img(pend_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
    endtask

    task automatic adv();
        if (imem_req && imem_gnt) pend_q.push_back(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string nm, input logic [31:0] pc);
        chk1({nm, "_valid"}, inst_valid, 1'b1);
        chk({nm, "_pc"}, inst_pc, pc);
        chk({nm, "_inst"}, inst, img(pc));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 32'h18, 1'b1, 32'h10};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        for (int i = 9; i <= 15; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 32'h10};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 32'h20, 1'b1, 32'h10};
        tbl[17] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};
        tbl[19] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1C};
        tbl[20] = '{1'b1, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h20};

        rst = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b1;
        mem_en = 1'b1; force_rv = 1'b0; force_data = '0;
        #2;
        chk1("rst_valid", inst_valid, 1'b0);
        chk1("rst_req", imem_req, 1'b0);
        chk("rst_inst", inst, NOP);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Stray response with nothing in flight must be ignored.
        force_rv = 1'b1; force_data = 32'hDEAD_BEEF;
        drive();
        chk1("stray_req", imem_req, 1'b1);
        chk("stray_addr", imem_addr, 32'h0);
        adv();
        force_rv = 1'b0;
        drive();
        chk1("stray_valid", inst_valid, 1'b0);
        chk("stray_inst", inst, NOP);
        adv();

        for (int i = 0; i < 21; i++) begin
            imem_gnt   = tbl[i].gnt;
            inst_ready = tbl[i].rdy;
            drive();
            chk1($sformatf("v%0d_req", i), imem_req, tbl[i].req);
            chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
            chk1($sformatf("v%0d_valid", i), inst_valid, tbl[i].vld);
            if (tbl[i].vld) chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].pc);
            chk($sformatf("v%0d_inst", i), inst, tbl[i].vld ? img(tbl[i].pc) : NOP);
            adv();
        end

        // Redirect with two fetches in flight: both responses dropped.
        mem_en = 1'b0; inst_ready = 1'b0;
        drive(); chk1("rdA_req", imem_req, 1'b1); chk("rdA_addr", imem_addr, 32'h30); adv();
        redirect = 1'b1; redirect_pc = 32'h100;
        drive(); chk1("rdB_valid", inst_valid, 1'b0); chk1("rdB_req", imem_req, 1'b0); adv();
        redirect = 1'b0; mem_en = 1'b1; inst_ready = 1'b1;
        drive(); chk1("rdC_req", imem_req, 1'b0); chk1("rdC_valid", inst_valid, 1'b0); adv();
        drive(); chk1("rdD_req", imem_req, 1'b1); chk("rdD_addr", imem_addr, 32'h100);
        chk1("rdD_valid", inst_valid, 1'b0); adv();
        drive(); chk1("rdE_valid", inst_valid, 1'b0); chk("rdE_addr", imem_addr, 32'h104); adv();
        drive(); chk_head("rdF", 32'h100); adv();

        // Unaligned redirect; response in the redirect cycle leaves nothing to drop.
        redirect = 1'b1; redirect_pc = 32'h103;
        drive(); chk1("alG_valid", inst_valid, 1'b0); adv();
        redirect = 1'b0;
        drive(); chk1("alH_req", imem_req, 1'b1); chk("alH_addr", imem_addr, 32'h100); adv();
        drive(); chk1("alI_valid", inst_valid, 1'b0); adv();
        drive(); chk_head("alJ", 32'h100); adv();

        // Fetch address wraps past 0xFFFF_FFFC.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        drive(); adv();
        redirect = 1'b0;
        drive(); chk1("wrL_req", imem_req, 1'b1); chk("wrL_addr", imem_addr, 32'hFFFF_FFFC); adv();
        drive(); chk("wrM_addr", imem_addr, 32'h0); adv();
        inst_ready = 1'b0;
        drive(); chk_head("wrN", 32'hFFFF_FFFC); adv();
        drive(); adv();

        // Asynchronous reset with three entries queued.
        drive(); chk_head("preRst", 32'hFFFF_FFFC);
        rst = 1'b0;
        pend_q.delete();
        #1;
        chk1("arst_valid", inst_valid, 1'b0);
        chk1("arst_req", imem_req, 1'b0);
        chk("arst_inst", inst, NOP);
        chk("arst_pc", inst_pc, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(); chk1("rel_req", imem_req, 1'b1); chk("rel_addr", imem_addr, 32'h0);
        chk1("rel_valid", inst_valid, 1'b0); adv();
        drive(); chk1("rel1_valid", inst_valid, 1'b0); adv();
        drive(); chk_head("rel2", 32'h0); adv();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
